// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one HD44780-style 8-bit write bus between two requesters.
// Each granted byte owns the bus for a fixed SLOT_CLKS-cycle slot; lcd_en is a
// registered pulse placed inside the slot, and the owner gets a one-cycle ack
// in the last cycle of its slot. Port 0 wins the first tie after reset.
module lcd_bus_arbiter #(
    parameter int SLOT_CLKS = 270000,
    parameter int EN_START  = 67499,
    parameter int EN_END    = 202499,
    parameter int TW        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    input  logic       lock0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    input  logic       lock1,
    output logic       ack1,
    output logic [1:0] grant,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    typedef enum logic {
        IDLE = 1'b0,
        SLOT = 1'b1
    } state_t;

    // One byte as presented by a requester.
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_word_t;

    localparam logic [TW-1:0] T_LAST  = TW'(SLOT_CLKS - 1);
    localparam logic [TW-1:0] T_EN_LO = TW'(EN_START);
    localparam logic [TW-1:0] T_EN_HI = TW'(EN_END);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            last_q;
    logic [1:0]      grant_q;
    lcd_word_t       word_q;
    logic            en_q, en_d;

    logic            any_req;
    logic            win;
    logic            slot_end;
    logic            take;
    lcd_word_t       win_word;

    assign any_req  = req0 | req1;
    assign slot_end = (state_q == SLOT) && (timer_q == T_LAST);
    assign take     = (state_q == IDLE) && any_req;

    // Winner selection, only meaningful while IDLE: a lone requester wins;
    // on a tie the previous owner keeps the bus if it holds its lock,
    // otherwise the other port gets its turn.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            if (last_q ? lock1 : lock0)
                win = last_q;
            else
                win = ~last_q;
        end else begin
            win = req1;
        end
    end

    // Byte of the winning port, captured onto the bus at the start of a slot.
    always_comb begin
        win_word = win ? lcd_word_t'{rs: rs1, data: data1}
                       : lcd_word_t'{rs: rs0, data: data0};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic plus slot timer and registered enable strobe decode.
    // The strobe is decoded from the next timer value so lcd_en lines up
    // exactly with the cycles whose timer lies in [EN_START, EN_END].
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            IDLE: begin
                if (any_req)
                    state_d = SLOT;
            end
            SLOT: begin
                if (slot_end)
                    state_d = IDLE;
                else
                    timer_d = timer_q + T_ONE;
            end
            default: state_d = IDLE;
        endcase
        en_d = (state_d == SLOT) && (timer_d >= T_EN_LO) && (timer_d <= T_EN_HI);
    end

    // Slot datapath: timer, owner, last winner and the latched LCD byte.
    // Reset clears everything at once, which also aborts a running slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
            en_q    <= 1'b0;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
            word_q  <= '0;
        end else begin
            timer_q <= timer_d;
            en_q    <= en_d;
            if (take) begin
                grant_q <= win ? 2'b10 : 2'b01;
                last_q  <= win;
                word_q  <= win_word;
            end else if (slot_end) begin
                grant_q <= 2'b00;
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy     = (state_q == SLOT);
        ack0     = slot_end & grant_q[0];
        ack1     = slot_end & grant_q[1];
        grant    = grant_q;
        lcd_en   = en_q;
        lcd_rs   = word_q.rs;
        lcd_data = word_q.data;
        lcd_rw   = 1'b0;
    end

    // Structural invariants of the arbiter.
    a_one_ack : assert property (@(posedge clk) disable iff (!reset) !(ack0 && ack1));
    a_one_own : assert property (@(posedge clk) disable iff (!reset) grant != 2'b11);
    a_busy_gr : assert property (@(posedge clk) disable iff (!reset) busy == (grant != 2'b00));

endmodule
